// File: rtl/uart_bank_if.sv
// Wishbone-classic bus bundle between a bus master and the UART register bank.
interface uart_bank_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_i,
    input  wb_dat_o, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_i,
    output wb_dat_o, wb_ack
  );
endinterface

// File: rtl/uart_bank.sv
// UART bus front end: Wishbone register bank, PHY control outputs, TX push /
// RX pop sequencing and the watermark interrupt.
module uart_bank #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868,
  localparam int         CW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  uart_bank_if.slave    wb,
  output logic          txen,
  output logic          rxen,
  output logic          nstop,
  output logic [15:0]   div,
  output logic [CW-1:0] txcnt,
  output logic [CW-1:0] rxcnt,
  output logic [7:0]    tx_fifo_wr_data,
  output logic          tx_fifo_wr_en,
  output logic          rx_fifo_rd_en,
  input  logic [7:0]    rx_fifo_rd_data,
  input  logic          tx_fifo_full,
  input  logic          rx_fifo_empty,
  input  logic          tx_fifo_less_than_watermark,
  input  logic          rx_fifo_greater_than_watermark,
  output logic          interrupt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  localparam logic [2:0] A_TXDATA = 3'd0;
  localparam logic [2:0] A_RXDATA = 3'd1;
  localparam logic [2:0] A_TXCTRL = 3'd2;
  localparam logic [2:0] A_RXCTRL = 3'd3;
  localparam logic [2:0] A_IE     = 3'd4;
  localparam logic [2:0] A_IP     = 3'd5;
  localparam logic [2:0] A_DIV    = 3'd6;

  logic [1:0]    state_q, state_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          rd_en_q, rd_en_d;
  logic          txen_q, txen_d;
  logic          nstop_q, nstop_d;
  logic [CW-1:0] txcnt_q, txcnt_d;
  logic          rxen_q, rxen_d;
  logic [CW-1:0] rxcnt_q, rxcnt_d;
  logic [1:0]    ie_q, ie_d;
  logic [15:0]   div_q, div_d;

  logic          req;
  logic          rx_pop;
  logic [1:0]    ip;
  logic [31:0]   rd_mux;
  logic          unused_dat_hi;

  assign req    = wb.wb_cyc & wb.wb_stb;
  assign rx_pop = req & ~wb.wb_we & (wb.wb_addr == A_RXDATA) & ~rx_fifo_empty;
  assign ip     = {rx_fifo_greater_than_watermark, tx_fifo_less_than_watermark};
  // Write-data bits above the widest field never reach a register.
  assign unused_dat_hi = ^wb.wb_dat_i[31:16+CW];

  // Read-data mux: register contents and live FIFO flags at request time.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    rd_mux = '0;
    case (wb.wb_addr)
      A_TXDATA: rd_mux[31] = tx_fifo_full;
      A_RXDATA: rd_mux[31] = rx_fifo_empty;  // non-empty reads take the POP path
      A_TXCTRL: begin
        rd_mux[0]       = txen_q;
        rd_mux[1]       = nstop_q;
        rd_mux[16 +: CW] = txcnt_q;
      end
      A_RXCTRL: begin
        rd_mux[0]       = rxen_q;
        rd_mux[16 +: CW] = rxcnt_q;
      end
      A_IE:     rd_mux[1:0]  = ie_q;
      A_IP:     rd_mux[1:0]  = ip;
      A_DIV:    rd_mux[15:0] = div_q;
      default:  rd_mux = '0;
    endcase
  end

  // Access FSM: decodes the request, schedules push/pop pulses and the ack.
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    dat_d     = dat_q;
    wr_data_d = wr_data_q;
    txen_d    = txen_q;
    nstop_d   = nstop_q;
    txcnt_d   = txcnt_q;
    rxen_d    = rxen_q;
    rxcnt_d   = rxcnt_q;
    ie_d      = ie_q;
    div_d     = div_q;
    case (state_q)
      S_IDLE: begin
        if (rx_pop) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end else if (req) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          dat_d   = wb.wb_we ? 32'h0 : rd_mux;
          if (wb.wb_we) begin
            case (wb.wb_addr)
              A_TXDATA: begin
                // A full FIFO drops the byte; the bus still completes.
                if (!tx_fifo_full) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = wb.wb_dat_i[7:0];
                end
              end
              A_TXCTRL: begin
                txen_d  = wb.wb_dat_i[0];
                nstop_d = wb.wb_dat_i[1];
                txcnt_d = wb.wb_dat_i[16 +: CW];
              end
              A_RXCTRL: begin
                rxen_d  = wb.wb_dat_i[0];
                rxcnt_d = wb.wb_dat_i[16 +: CW];
              end
              A_IE:    ie_d  = wb.wb_dat_i[1:0];
              A_DIV:   div_d = wb.wb_dat_i[15:0];
              default: ;
            endcase
          end
        end
      end
      S_POP:  state_d = S_CAPT;
      S_CAPT: begin
        // FIFO head is valid now, one cycle after the pop pulse.
        dat_d   = {24'h0, rx_fifo_rd_data};
        state_d = S_ACK;
        ack_d   = 1'b1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and register flops; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      txen_q    <= 1'b0;
      nstop_q   <= 1'b0;
      txcnt_q   <= '0;
      rxen_q    <= 1'b0;
      rxcnt_q   <= '0;
      ie_q      <= '0;
      div_q     <= DIV_RESET;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      txen_q    <= txen_d;
      nstop_q   <= nstop_d;
      txcnt_q   <= txcnt_d;
      rxen_q    <= rxen_d;
      rxcnt_q   <= rxcnt_d;
      ie_q      <= ie_d;
      div_q     <= div_d;
    end
  end

  assign wb.wb_ack       = ack_q;
  assign wb.wb_dat_o     = dat_q;
  assign tx_fifo_wr_en   = wr_en_q;
  assign tx_fifo_wr_data = wr_data_q;
  assign rx_fifo_rd_en   = rd_en_q;
  assign txen            = txen_q;
  assign nstop           = nstop_q;
  assign txcnt           = txcnt_q;
  assign rxen            = rxen_q;
  assign rxcnt           = rxcnt_q;
  assign div             = div_q;
  assign interrupt       = |(ie_q & ip);

endmodule

// File: tb/tb_uart_bank.sv
// Self-checking bench for uart_bank: directed scenarios plus a randomized
// access stream checked against a register-map model.
module tb_uart_bank;

  localparam int          CW        = $clog2(8);
  localparam logic [15:0] DIV_RESET = 16'd868;
  localparam logic [31:0] TXCTRL_MASK = 32'h3 | (((32'h1 << CW) - 1) << 16);
  localparam logic [31:0] RXCTRL_MASK = 32'h1 | (((32'h1 << CW) - 1) << 16);

  logic          clock = 1'b0;
  logic          reset;
  logic          txen, rxen, nstop;
  logic [15:0]   div;
  logic [CW-1:0] txcnt, rxcnt;
  logic [7:0]    tx_fifo_wr_data;
  logic          tx_fifo_wr_en, rx_fifo_rd_en;
  logic [7:0]    rx_fifo_rd_data;
  logic          tx_fifo_full, rx_fifo_empty;
  logic          tx_less, rx_gt;
  logic          interrupt;
  logic [7:0]    rx_head;

  int checks = 0;
  int errors = 0;

  // Model of the programmable registers, as they read back on the bus.
  logic [31:0] m_txctrl, m_rxctrl;
  logic [1:0]  m_ie;
  logic [15:0] m_div;

  uart_bank_if bus ();

  uart_bank dut (
    .clock                          (clock),
    .reset                          (reset),
    .wb                             (bus),
    .txen                           (txen),
    .rxen                           (rxen),
    .nstop                          (nstop),
    .div                            (div),
    .txcnt                          (txcnt),
    .rxcnt                          (rxcnt),
    .tx_fifo_wr_data                (tx_fifo_wr_data),
    .tx_fifo_wr_en                  (tx_fifo_wr_en),
    .rx_fifo_rd_en                  (rx_fifo_rd_en),
    .rx_fifo_rd_data                (rx_fifo_rd_data),
    .tx_fifo_full                   (tx_fifo_full),
    .rx_fifo_empty                  (rx_fifo_empty),
    .tx_fifo_less_than_watermark    (tx_less),
    .rx_fifo_greater_than_watermark (rx_gt),
    .interrupt                      (interrupt)
  );

  always #5 clock = ~clock;

  // RX FIFO model: head byte appears the cycle after a pop, garbage otherwise.
  always @(posedge clock) begin
    if (rx_fifo_rd_en) rx_fifo_rd_data <= rx_head;
    else               rx_fifo_rd_data <= ~rx_head;
  end

  function automatic void model_reset();
    m_txctrl = '0;
    m_rxctrl = '0;
    m_ie     = '0;
    m_div    = DIV_RESET;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd2:    m_txctrl = d & TXCTRL_MASK;
      3'd3:    m_rxctrl = d & RXCTRL_MASK;
      3'd4:    m_ie     = d[1:0];
      3'd6:    m_div    = d[15:0];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {tx_fifo_full, 31'h0};
      3'd1:    return rx_fifo_empty ? 32'h8000_0000 : {24'h0, rx_head};
      3'd2:    return m_txctrl;
      3'd3:    return m_rxctrl;
      3'd4:    return {30'h0, m_ie};
      3'd5:    return {30'h0, rx_gt, tx_less};
      3'd6:    return {16'h0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  // One bus access; reports data, cycles to ack (-1 on timeout) and pulses seen.
  task automatic wb_access(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat, output int n_wr,
                           output int n_rd, output int n_both, output logic [7:0] wr_byte,
                           output logic ack_after);
    @(negedge clock);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_addr  = addr;
    bus.wb_dat_i = wdata;
    lat = -1; n_wr = 0; n_rd = 0; n_both = 0; rdata = '0; wr_byte = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (tx_fifo_wr_en) begin n_wr++; wr_byte = tx_fifo_wr_data; end
      if (rx_fifo_rd_en) n_rd++;
      if (tx_fifo_wr_en && rx_fifo_rd_en) n_both++;
      if (bus.wb_ack) begin lat = c; rdata = bus.wb_dat_o; break; end
    end
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
    @(posedge clock); #1;
    if (tx_fifo_wr_en) n_wr++;
    if (rx_fifo_rd_en) n_rd++;
    ack_after = bus.wb_ack;
  endtask

  task automatic test_reset();
    tx_less = 1'b1; rx_gt = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.wb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.wb_ack); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.wb_dat_o); end
    checks++; if ({tx_fifo_wr_en, rx_fifo_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {tx_fifo_wr_en, rx_fifo_rd_en}); end
    checks++; if ({txen, rxen, nstop} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {txen, rxen, nstop}); end
    checks++; if ({txcnt, rxcnt} !== '0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {txcnt, rxcnt}); end
    checks++; if (div !== DIV_RESET) begin errors++; $display("FAIL reset_div: got %h want %h", div, DIV_RESET); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", interrupt); end
    @(negedge clock);
    reset = 1'b0;
    tx_less = 1'b0; rx_gt = 1'b0;
    model_reset();
  endtask

  task automatic test_register_access();
    logic [31:0] rd; int lat, nw, nr, nb; logic [7:0] wb_b; logic aa;
    wb_access(1'b0, 3'd6, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_read_lat: got %0d want 1", lat); end
    checks++; if (rd !== 32'h0000_0364) begin errors++; $display("FAIL div_read: got %h want 00000364", rd); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b want 0", aa); end
    wb_access(1'b0, 3'd2, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL txctrl_reset_read: got %h want 0", rd); end
    wb_access(1'b1, 3'd2, 32'h0003_0003, rd, lat, nw, nr, nb, wb_b, aa);
    model_write(3'd2, 32'h0003_0003);
    checks++; if ({txen, nstop, txcnt} !== {1'b1, 1'b1, 3'd3}) begin errors++; $display("FAIL txctrl_fields: got %b want 11011", {txen, nstop, txcnt}); end
    wb_access(1'b0, 3'd2, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (rd !== 32'h0003_0003) begin errors++; $display("FAIL txctrl_readback: got %h want 00030003", rd); end
    // The div write must already be visible during the ack cycle.
    @(negedge clock);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = 3'd6; bus.wb_dat_i = 32'h0000_1234;
    @(posedge clock); #1;
    checks++; if ({bus.wb_ack, div} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL div_write_edge: got %h want 11234", {bus.wb_ack, div}); end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    @(posedge clock); #1;
    model_write(3'd6, 32'h0000_1234);
    wb_access(1'b1, 3'd5, 32'hFFFF_FFFF, rd, lat, nw, nr, nb, wb_b, aa);
    wb_access(1'b0, 3'd5, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ip_write_ignored: got %h want 0", rd); end
    wb_access(1'b1, 3'd7, 32'hFFFF_FFFF, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (lat !== 1) begin errors++; $display("FAIL addr7_write_ack: got %0d want 1", lat); end
    wb_access(1'b0, 3'd7, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL addr7_read: got %h want 0", rd); end
  endtask

  task automatic test_tx_push();
    logic [31:0] rd; int lat, nw, nr, nb; logic [7:0] wb_b; logic aa;
    tx_fifo_full = 1'b0;
    wb_access(1'b1, 3'd0, 32'h0000_0041, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (nw !== 1) begin errors++; $display("FAIL tx_push_count: got %0d want 1", nw); end
    checks++; if (wb_b !== 8'h41) begin errors++; $display("FAIL tx_push_data: got %h want 41", wb_b); end
    tx_fifo_full = 1'b1;
    wb_access(1'b1, 3'd0, 32'h0000_0042, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (lat !== 1) begin errors++; $display("FAIL tx_full_ack: got %0d want 1", lat); end
    checks++; if (nw !== 0) begin errors++; $display("FAIL tx_full_no_push: got %0d want 0", nw); end
    wb_access(1'b0, 3'd0, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL txdata_full_read: got %h want 80000000", rd); end
    tx_fifo_full = 1'b0;
  endtask

  task automatic test_rx_pop();
    logic [31:0] rd; int lat, nw, nr, nb; logic [7:0] wb_b; logic aa;
    rx_fifo_empty = 1'b0; rx_head = 8'h5A;
    wb_access(1'b0, 3'd1, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rx_pop_lat: got %0d want 3", lat); end
    checks++; if (nr !== 1) begin errors++; $display("FAIL rx_pop_count: got %0d want 1", nr); end
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL rx_pop_data: got %h want 0000005a", rd); end
    rx_fifo_empty = 1'b1;
    wb_access(1'b0, 3'd1, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rx_empty_lat: got %0d want 1", lat); end
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL rx_empty_data: got %h want 80000000", rd); end
    checks++; if (nr !== 0) begin errors++; $display("FAIL rx_empty_no_pop: got %0d want 0", nr); end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd; int lat, nw, nr, nb; logic [7:0] wb_b; logic aa;
    wb_access(1'b1, 3'd4, 32'h0000_0003, rd, lat, nw, nr, nb, wb_b, aa);
    model_write(3'd4, 32'h3);
    rx_gt = 1'b1; tx_less = 1'b0; #1;
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_rxwm: got %b want 1", interrupt); end
    wb_access(1'b0, 3'd5, 32'h0, rd, lat, nw, nr, nb, wb_b, aa);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ip_read: got %h want 2", rd); end
    wb_access(1'b1, 3'd4, 32'h0000_0001, rd, lat, nw, nr, nb, wb_b, aa);
    model_write(3'd4, 32'h1);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", interrupt); end
    tx_less = 1'b1; #1;
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_txwm_comb: got %b want 1", interrupt); end
    rx_gt = 1'b0; tx_less = 1'b0;
  endtask

  task automatic test_sample_time();
    tx_fifo_full = 1'b1;
    @(negedge clock);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_addr = 3'd0;
    @(posedge clock); #1;
    tx_fifo_full = 1'b0;
    #2;
    checks++; if ({bus.wb_ack, bus.wb_dat_o} !== {1'b1, 32'h8000_0000}) begin errors++; $display("FAIL read_sampled_at_request: got %h want 180000000", {bus.wb_ack, bus.wb_dat_o}); end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_stb_without_cyc();
    int bad = 0;
    @(negedge clock);
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = 3'd6; bus.wb_dat_i = 32'h0000_BEEF;
    repeat (4) begin
      @(posedge clock); #1;
      if (bus.wb_ack) bad++;
    end
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
      if (bus.wb_ack) bad++;
    end
    bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL stb_without_cyc_ack: got %0d acks want 0", bad); end
    checks++; if (div !== m_div) begin errors++; $display("FAIL stb_without_cyc_div: got %h want %h", div, m_div); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_rd; int lat, nw, nr, nb, exp_lat; logic [7:0] wb_b; logic aa, we;
    logic [2:0] a; logic exp_push, exp_pop;
    for (int i = 0; i < 80; i++) begin
      tx_fifo_full  = 1'($urandom_range(0, 1));
      rx_fifo_empty = 1'($urandom_range(0, 1));
      tx_less       = 1'($urandom_range(0, 1));
      rx_gt         = 1'($urandom_range(0, 1));
      rx_head       = 8'($urandom);
      a  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      exp_rd   = model_read(a);
      exp_pop  = !we && a == 3'd1 && !rx_fifo_empty;
      exp_push = we && a == 3'd0 && !tx_fifo_full;
      exp_lat  = exp_pop ? 3 : 1;
      if (we) model_write(a, d);
      wb_access(we, a, d, rd, lat, nw, nr, nb, wb_b, aa);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d] a=%0d we=%b: got %0d want %0d", i, a, we, lat, exp_lat); end
      if (!we) begin
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d] a=%0d: got %h want %h", i, a, rd, exp_rd); end
      end
      checks++; if (nw !== int'(exp_push)) begin errors++; $display("FAIL rnd_push[%0d]: got %0d want %0d", i, nw, exp_push); end
      if (exp_push) begin
        checks++; if (wb_b !== d[7:0]) begin errors++; $display("FAIL rnd_push_data[%0d]: got %h want %h", i, wb_b, d[7:0]); end
      end
      checks++; if (nr !== int'(exp_pop)) begin errors++; $display("FAIL rnd_pop[%0d]: got %0d want %0d", i, nr, exp_pop); end
      checks++; if (nb !== 0 || aa !== 1'b0) begin errors++; $display("FAIL rnd_exclusive[%0d]: got both=%0d ack_after=%b want 0 0", i, nb, aa); end
      checks++; if ({txen, nstop, txcnt, rxen, rxcnt, div} !== {m_txctrl[0], m_txctrl[1], m_txctrl[16 +: CW], m_rxctrl[0], m_rxctrl[16 +: CW], m_div})
        begin errors++; $display("FAIL rnd_outputs[%0d]: got %h want %h", i, {txen, nstop, txcnt, rxen, rxcnt, div}, {m_txctrl[0], m_txctrl[1], m_txctrl[16 +: CW], m_rxctrl[0], m_rxctrl[16 +: CW], m_div}); end
      checks++; if (interrupt !== |(m_ie & {rx_gt, tx_less})) begin errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, interrupt, |(m_ie & {rx_gt, tx_less})); end
    end
    tx_fifo_full = 1'b0; rx_fifo_empty = 1'b1; tx_less = 1'b0; rx_gt = 1'b0;
  endtask

  task automatic test_reset_mid_pop();
    logic [31:0] rd; int lat, nw, nr, nb, bad; logic [7:0] wb_b; logic aa;
    wb_access(1'b1, 3'd6, 32'h0000_1234, rd, lat, nw, nr, nb, wb_b, aa);
    model_write(3'd6, 32'h1234);
    rx_fifo_empty = 1'b0; rx_head = 8'hC3;
    @(negedge clock);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_addr = 3'd1;
    @(posedge clock); #1;
    checks++; if (rx_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL pop_before_reset: got %b want 1", rx_fifo_rd_en); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({rx_fifo_rd_en, bus.wb_ack} !== 2'b00) begin errors++; $display("FAIL reset_kills_pop: got %b want 00", {rx_fifo_rd_en, bus.wb_ack}); end
    checks++; if (div !== DIV_RESET) begin errors++; $display("FAIL reset_mid_div: got %h want %h", div, DIV_RESET); end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    bad = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (bus.wb_ack || rx_fifo_rd_en) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL no_ack_after_reset: got %0d events want 0", bad); end
    rx_fifo_empty = 1'b1;
  endtask

  initial begin
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_dat_i = '0;
    tx_fifo_full = 1'b0; rx_fifo_empty = 1'b1; tx_less = 1'b0; rx_gt = 1'b0; rx_head = 8'h00;
    model_reset();
    test_reset();
    test_register_access();
    test_tx_push();
    test_rx_pop();
    test_interrupt();
    test_sample_time();
    test_stb_without_cyc();
    test_random();
    test_reset_mid_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
